// File: rtl/rng_sched_pkg.sv
// Shared types and helpers for the RNG share scheduler.
// Optional feature macro: RNG_SCHED_ABORT_EN (see rng_share_scheduler.sv).
package rng_sched_pkg;

  localparam int NREQ_DFLT = 4;
  localparam int RWID_DFLT = 10;
  localparam int PIPE_DFLT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Effective window length: an encoded 0 stands for the full 2**rwid window.
  function automatic logic [31:0] len_decode(input logic [31:0] win_len, input int rwid);
    return (win_len == 32'd0) ? (32'd1 << rwid) : win_len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner is the first set req
// strictly after ptr (mod NREQ), so the previous owner has lowest priority.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan NREQ positions starting just past the pointer, keep the first hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_share_scheduler.sv
// Time-multiplexes one shared RNG bank among NREQ requesters, one window at a
// time: IDLE -> FILL (PIPE cycles) -> RUN (L cycles) -> DONE (1 cycle).
// Optional macro RNG_SCHED_ABORT_EN: owner dropping req in FILL/RUN aborts the
// window (back to IDLE, no done pulse).
module rng_share_scheduler
  import rng_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT,
  parameter int RWID = RWID_DFLT,
  parameter int PIPE = PIPE_DFLT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [RWID:0]   winLen,
  output logic [NREQ-1:0] grant,
  output logic            rngEnable,
  output logic            rngValid,
  output logic [RWID:0]   cycleCnt,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = RWID + 1;
  localparam int FW = (PIPE > 1) ? $clog2(PIPE) : 1;

  state_e          state, state_nxt;
  logic [PW-1:0]   ptr, win_idx;
  logic [NREQ-1:0] winner;
  logic [CW-1:0]   len;
  logic [FW-1:0]   fcnt;
  logic            abort, fill_last, run_last;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .winner(winner)
  );

  // Winner one-hot back to an index for the pointer register.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (winner[i]) win_idx = PW'(i);
  end

`ifdef RNG_SCHED_ABORT_EN
  assign abort = ((state == FILL) || (state == RUN)) && ~|(req & grant);
`else
  assign abort = 1'b0;
`endif

  assign fill_last = (fcnt == FW'(PIPE - 1));
  assign run_last  = (cycleCnt == len - CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; req only matters in IDLE (and for abort when enabled).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req) state_nxt = FILL;
      FILL: if (abort) state_nxt = IDLE;
            else if (fill_last) state_nxt = RUN;
      RUN:  if (abort) state_nxt = IDLE;
            else if (run_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, pointer, latched length and the fill/run counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant    <= '0;
      ptr      <= PW'(NREQ - 1);
      len      <= '0;
      fcnt     <= '0;
      cycleCnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant <= winner;
          ptr   <= win_idx;
          len   <= CW'(len_decode(32'(winLen), RWID));
          fcnt  <= '0;
        end
        FILL: begin
          fcnt <= fcnt + FW'(1);
          if (state_nxt == IDLE) grant <= '0;
        end
        RUN: begin
          cycleCnt <= (state_nxt == RUN) ? cycleCnt + CW'(1) : '0;
          if (state_nxt == IDLE) grant <= '0;
        end
        DONE: grant <= '0;
        default: grant <= '0;
      endcase
    end
  end

  assign rngEnable = (state == FILL) || (state == RUN);
  assign rngValid  = (state == RUN);
  assign done      = (state == DONE) ? grant : '0;
  assign busy      = (state != IDLE);

endmodule
